// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath widths, ALU opcodes and B-operand select encodings.
package cpu_defs;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned REG_AW     = 5;

  // ALU opcodes; values outside this set are carried through untouched.
  typedef enum logic [3:0] {
    AluAnd  = 4'd0,
    AluOr   = 4'd1,
    AluAdd  = 4'd2,
    AluLui  = 4'd3,
    AluSltu = 4'd4,
    AluSll  = 4'd5,
    AluSub  = 4'd6,
    AluSlt  = 4'd7
  } alu_op_e;

  // Source of ALU operand B.
  typedef enum logic [1:0] {
    BSelRt   = 2'd0,
    BSelSext = 2'd1,
    BSelZext = 2'd2,
    BSelZero = 2'd3
  } b_sel_e;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundle between decode, the EX operand stage, its ALU and the MEM/WB write ports.
// master drives the stage inputs, slave is the stage itself.
interface ex_operand_stage_if #(
  parameter int unsigned DATA_WIDTH = cpu_defs::DATA_WIDTH,
  parameter int unsigned REG_AW     = cpu_defs::REG_AW
);

  // Decode side
  logic                  de_valid;
  logic                  de_ready;
  logic [REG_AW-1:0]     de_rs_addr;
  logic [REG_AW-1:0]     de_rt_addr;
  logic [DATA_WIDTH-1:0] de_rs_val;
  logic [DATA_WIDTH-1:0] de_rt_val;
  logic                  de_use_rs;
  logic                  de_use_rt;
  logic [15:0]           de_imm;
  logic [4:0]            de_sa;
  logic                  de_a_sel;
  logic [1:0]            de_b_sel;
  logic [3:0]            de_alu_op;
  logic [REG_AW-1:0]     de_dest;
  logic                  de_wen;
  logic                  de_is_load;

  // Execute / downstream side
  logic [DATA_WIDTH-1:0] ex_alu_result;
  logic                  ex_allowin;
  logic                  ex_valid;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [3:0]            alu_op;
  logic [REG_AW-1:0]     ex_dest;
  logic                  ex_wen;
  logic                  ex_is_load;

  // Later-stage write ports used for forwarding
  logic                  mem_wen;
  logic [REG_AW-1:0]     mem_dest;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  wb_wen;
  logic [REG_AW-1:0]     wb_dest;
  logic [DATA_WIDTH-1:0] wb_wdata;

  modport master (
    output de_valid, de_rs_addr, de_rt_addr, de_rs_val, de_rt_val, de_use_rs, de_use_rt,
           de_imm, de_sa, de_a_sel, de_b_sel, de_alu_op, de_dest, de_wen, de_is_load,
           ex_alu_result, ex_allowin, mem_wen, mem_dest, mem_wdata, wb_wen, wb_dest, wb_wdata,
    input  de_ready, ex_valid, alu_a, alu_b, alu_op, ex_dest, ex_wen, ex_is_load
  );

  modport slave (
    input  de_valid, de_rs_addr, de_rt_addr, de_rs_val, de_rt_val, de_use_rs, de_use_rt,
           de_imm, de_sa, de_a_sel, de_b_sel, de_alu_op, de_dest, de_wen, de_is_load,
           ex_alu_result, ex_allowin, mem_wen, mem_dest, mem_wdata, wb_wen, wb_dest, wb_wdata,
    output de_ready, ex_valid, alu_a, alu_b, alu_op, ex_dest, ex_wen, ex_is_load
  );

endinterface

// File: rtl/operand_fwd.sv
// Resolves one source register: register 0 is hardwired, otherwise the youngest matching
// write port (EX, then MEM, then WB) wins over the register-file read.
module operand_fwd #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_AW     = 5
) (
  input  logic [REG_AW-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] rf_val,
  input  logic                  ex_en,
  input  logic [REG_AW-1:0]     ex_dest,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic                  mem_en,
  input  logic [REG_AW-1:0]     mem_dest,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  wb_en,
  input  logic [REG_AW-1:0]     wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] val
);

  // Priority select of the freshest producer of this register.
  always_comb begin
    val = rf_val;
    if (addr == '0) begin
      val = '0;
    end else if (ex_en && (ex_dest == addr)) begin
      val = ex_data;
    end else if (mem_en && (mem_dest == addr)) begin
      val = mem_data;
    end else if (wb_en && (wb_dest == addr)) begin
      val = wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register: captures a decoded instruction with fully forwarded operands,
// stalls decode on load-use and handshakes with decode and the memory stage.
module ex_operand_stage #(
  parameter int unsigned DATA_WIDTH = cpu_defs::DATA_WIDTH,
  parameter int unsigned REG_AW     = cpu_defs::REG_AW
) (
  input logic               clk,
  input logic               resetn,
  ex_operand_stage_if.slave bus
);

  import cpu_defs::*;

  logic                  ex_valid_q, ex_valid_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]            alu_op_q;
  logic [REG_AW-1:0]     ex_dest_q;
  logic                  ex_wen_q;
  logic                  ex_is_load_q;

  logic                  de_allowin;
  logic                  load_hazard;
  logic                  de_ready;
  logic                  de_fire;
  logic                  ex_fire;
  logic                  ex_fwd_en;
  logic [DATA_WIDTH-1:0] rs_fwd;
  logic [DATA_WIDTH-1:0] rt_fwd;

  // A load's data is not in ex_alu_result, so it must never forward from EX.
  assign ex_fwd_en = ex_valid_q & ex_wen_q & ~ex_is_load_q;

  // Handshake and load-use detection; deliberately independent of ex_alu_result.
  always_comb begin
    ex_fire     = ex_valid_q & bus.ex_allowin;
    de_allowin  = ~ex_valid_q | bus.ex_allowin;
    load_hazard = ex_valid_q & ex_is_load_q & ex_wen_q & (ex_dest_q != '0) &
                  ((bus.de_use_rs & (bus.de_rs_addr == ex_dest_q)) |
                   (bus.de_use_rt & (bus.de_rt_addr == ex_dest_q)));
    de_ready    = de_allowin & ~load_hazard;
    de_fire     = bus.de_valid & de_ready;
  end

  operand_fwd #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_AW    (REG_AW)
  ) u_fwd_rs (
    .addr    (bus.de_rs_addr),
    .rf_val  (bus.de_rs_val),
    .ex_en   (ex_fwd_en),
    .ex_dest (ex_dest_q),
    .ex_data (bus.ex_alu_result),
    .mem_en  (bus.mem_wen),
    .mem_dest(bus.mem_dest),
    .mem_data(bus.mem_wdata),
    .wb_en   (bus.wb_wen),
    .wb_dest (bus.wb_dest),
    .wb_data (bus.wb_wdata),
    .val     (rs_fwd)
  );

  operand_fwd #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_AW    (REG_AW)
  ) u_fwd_rt (
    .addr    (bus.de_rt_addr),
    .rf_val  (bus.de_rt_val),
    .ex_en   (ex_fwd_en),
    .ex_dest (ex_dest_q),
    .ex_data (bus.ex_alu_result),
    .mem_en  (bus.mem_wen),
    .mem_dest(bus.mem_dest),
    .mem_data(bus.mem_wdata),
    .wb_en   (bus.wb_wen),
    .wb_dest (bus.wb_dest),
    .wb_data (bus.wb_wdata),
    .val     (rt_fwd)
  );

  // Operand selection for the instruction being captured.
  always_comb begin
    alu_a_d = bus.de_a_sel ? {{(DATA_WIDTH-5){1'b0}}, bus.de_sa} : rs_fwd;
    alu_b_d = '0;
    case (b_sel_e'(bus.de_b_sel))
      BSelRt:   alu_b_d = rt_fwd;
      BSelSext: alu_b_d = {{(DATA_WIDTH-16){bus.de_imm[15]}}, bus.de_imm};
      BSelZext: alu_b_d = {{(DATA_WIDTH-16){1'b0}}, bus.de_imm};
      BSelZero: alu_b_d = '0;
      default:  alu_b_d = '0;
    endcase
  end

  // Valid bit: fill on capture, drain to a bubble when only the old instruction leaves.
  always_comb begin
    ex_valid_d = ex_valid_q;
    if (de_fire) begin
      ex_valid_d = 1'b1;
    end else if (ex_fire) begin
      ex_valid_d = 1'b0;
    end
  end

  // Stage registers; payload loads only on capture so a stalled instruction is frozen.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      ex_dest_q    <= '0;
      ex_wen_q     <= 1'b0;
      ex_is_load_q <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (de_fire) begin
        alu_a_q      <= alu_a_d;
        alu_b_q      <= alu_b_d;
        alu_op_q     <= bus.de_alu_op;
        ex_dest_q    <= bus.de_dest;
        ex_wen_q     <= bus.de_wen;
        ex_is_load_q <= bus.de_is_load;
      end
    end
  end

  assign bus.de_ready   = de_ready;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.ex_dest    = ex_dest_q;
  assign bus.ex_wen     = ex_wen_q;
  assign bus.ex_is_load = ex_is_load_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: pass-through, forwarding priority, load-use bubble,
// immediates, register zero, downstream stall and asynchronous reset.
module tb_ex_operand_stage;

  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        resetn;
  int unsigned errors = 0;
  int unsigned checks = 0;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic de_clear();
    bus.de_valid   = 1'b0;
    bus.de_rs_addr = '0;
    bus.de_rt_addr = '0;
    bus.de_rs_val  = '0;
    bus.de_rt_val  = '0;
    bus.de_use_rs  = 1'b0;
    bus.de_use_rt  = 1'b0;
    bus.de_imm     = '0;
    bus.de_sa      = '0;
    bus.de_a_sel   = 1'b0;
    bus.de_b_sel   = '0;
    bus.de_alu_op  = '0;
    bus.de_dest    = '0;
    bus.de_wen     = 1'b0;
    bus.de_is_load = 1'b0;
  endtask

  task automatic de_issue(input logic [4:0] rs, input logic [31:0] rs_val,
                          input logic [4:0] rt, input logic [31:0] rt_val,
                          input logic [1:0] b_sel, input logic [3:0] op,
                          input logic [4:0] dest, input logic is_load);
    bus.de_valid   = 1'b1;
    bus.de_rs_addr = rs;
    bus.de_rs_val  = rs_val;
    bus.de_rt_addr = rt;
    bus.de_rt_val  = rt_val;
    bus.de_use_rs  = 1'b1;
    bus.de_use_rt  = (b_sel == BSelRt);
    bus.de_b_sel   = b_sel;
    bus.de_alu_op  = op;
    bus.de_dest    = dest;
    bus.de_wen     = 1'b1;
    bus.de_is_load = is_load;
  endtask

  initial begin
    resetn            = 1'b0;
    de_clear();
    bus.ex_allowin    = 1'b1;
    bus.ex_alu_result = '0;
    bus.mem_wen       = 1'b0;
    bus.mem_dest      = '0;
    bus.mem_wdata     = '0;
    bus.wb_wen        = 1'b0;
    bus.wb_dest       = '0;
    bus.wb_wdata      = '0;
    #12;

    check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_ex_dest", 32'(bus.ex_dest), 32'd0);
    check("rst_ex_wen", 32'(bus.ex_wen), 32'd0);
    check("rst_ex_is_load", 32'(bus.ex_is_load), 32'd0);
    resetn = 1'b1;

    // Pass-through: ADD $3 = $1(5) + $2(7)
    de_issue(5'd1, 32'd5, 5'd2, 32'd7, BSelRt, AluAdd, 5'd3, 1'b0);
    #1;
    check("pass_de_ready", 32'(bus.de_ready), 32'd1);
    tick();
    check("pass_ex_valid", 32'(bus.ex_valid), 32'd1);
    check("pass_alu_a", bus.alu_a, 32'd5);
    check("pass_alu_b", bus.alu_b, 32'd7);
    check("pass_alu_op", 32'(bus.alu_op), 32'd2);
    check("pass_ex_dest", 32'(bus.ex_dest), 32'd3);

    // EX forward beats MEM and WB for $3
    bus.ex_alu_result = 32'h10;
    bus.mem_wen = 1'b1; bus.mem_dest = 5'd3; bus.mem_wdata = 32'h55;
    bus.wb_wen  = 1'b1; bus.wb_dest  = 5'd3; bus.wb_wdata  = 32'h66;
    de_issue(5'd3, 32'h99, 5'd0, 32'd0, BSelZero, AluSub, 5'd5, 1'b0);
    tick();
    check("exfwd_alu_a", bus.alu_a, 32'h10);
    check("exfwd_alu_b", bus.alu_b, 32'h0);
    check("exfwd_alu_op", 32'(bus.alu_op), 32'd6);

    // MEM beats WB
    bus.mem_dest = 5'd7; bus.mem_wdata = 32'h77;
    bus.wb_dest  = 5'd7; bus.wb_wdata  = 32'h88;
    de_issue(5'd7, 32'h1, 5'd7, 32'h2, BSelRt, AluOr, 5'd8, 1'b0);
    tick();
    check("memfwd_alu_a", bus.alu_a, 32'h77);
    check("memfwd_alu_b", bus.alu_b, 32'h77);

    // WB only; rt not matching stays register-file value
    bus.mem_wen = 1'b0;
    de_issue(5'd7, 32'h1, 5'd2, 32'h2, BSelRt, AluAnd, 5'd8, 1'b0);
    tick();
    check("wbfwd_alu_a", bus.alu_a, 32'h88);
    check("wbfwd_alu_b", bus.alu_b, 32'h2);
    bus.wb_wen = 1'b0;

    // Load $4 = mem[$1 + 4]
    de_issue(5'd1, 32'h100, 5'd0, 32'd0, BSelSext, AluAdd, 5'd4, 1'b1);
    bus.de_imm = 16'h0004;
    tick();
    check("ld_is_load", 32'(bus.ex_is_load), 32'd1);
    check("ld_alu_a", bus.alu_a, 32'h100);
    check("ld_alu_b", bus.alu_b, 32'h4);

    // Dependent OR reads $4 as rt: one bubble, then MEM forwards
    de_issue(5'd0, 32'd0, 5'd4, 32'd0, BSelRt, AluOr, 5'd6, 1'b0);
    bus.de_imm = 16'h0000;
    #1;
    check("lu_de_ready_stall", 32'(bus.de_ready), 32'd0);
    tick();
    check("lu_bubble", 32'(bus.ex_valid), 32'd0);
    bus.mem_wen = 1'b1; bus.mem_dest = 5'd4; bus.mem_wdata = 32'hABCD;
    #1;
    check("lu_de_ready_free", 32'(bus.de_ready), 32'd1);
    tick();
    check("lu_ex_valid", 32'(bus.ex_valid), 32'd1);
    check("lu_alu_b", bus.alu_b, 32'hABCD);
    check("lu_ex_dest", 32'(bus.ex_dest), 32'd6);
    bus.mem_wen = 1'b0;

    // Immediates and shift amount
    de_issue(5'd0, 32'd0, 5'd0, 32'd0, BSelSext, AluSll, 5'd9, 1'b0);
    bus.de_imm = 16'h8001; bus.de_a_sel = 1'b1; bus.de_sa = 5'd3;
    tick();
    check("imm_sext", bus.alu_b, 32'hFFFF8001);
    check("imm_sa", bus.alu_a, 32'h3);
    bus.de_b_sel = BSelZext;
    tick();
    check("imm_zext", bus.alu_b, 32'h00008001);

    // Register zero ignores forwarding; unknown opcode passes through
    bus.de_a_sel = 1'b0; bus.de_sa = 5'd0; bus.de_imm = 16'h0;
    bus.mem_wen = 1'b1; bus.mem_dest = 5'd0; bus.mem_wdata = 32'd9;
    bus.wb_wen  = 1'b1; bus.wb_dest  = 5'd0; bus.wb_wdata  = 32'd9;
    de_issue(5'd0, 32'd0, 5'd0, 32'd0, BSelZero, 4'hD, 5'd0, 1'b0);
    tick();
    check("r0_alu_a", bus.alu_a, 32'd0);
    check("r0_alu_op", 32'(bus.alu_op), 32'hD);
    bus.mem_wen = 1'b0; bus.wb_wen = 1'b0;

    // Downstream stall for 3 cycles with a new instruction waiting
    bus.ex_allowin = 1'b0;
    de_issue(5'd1, 32'h5A5A, 5'd2, 32'h3, BSelRt, AluSlt, 5'd10, 1'b0);
    #1;
    check("stall_de_ready_0", 32'(bus.de_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ex_valid", 32'(bus.ex_valid), 32'd1);
      check("stall_alu_a", bus.alu_a, 32'd0);
      check("stall_alu_op", 32'(bus.alu_op), 32'hD);
      check("stall_de_ready", 32'(bus.de_ready), 32'd0);
    end

    // Release: waiting instruction replaces held one without a bubble
    bus.ex_allowin = 1'b1;
    #1;
    check("release_de_ready", 32'(bus.de_ready), 32'd1);
    tick();
    check("release_ex_valid", 32'(bus.ex_valid), 32'd1);
    check("release_alu_a", bus.alu_a, 32'h5A5A);
    check("release_alu_b", bus.alu_b, 32'h3);
    check("release_alu_op", 32'(bus.alu_op), 32'd7);

    // Asynchronous reset between edges while stalled
    bus.ex_allowin = 1'b0;
    tick();
    #3;
    resetn = 1'b0;
    #1;
    check("areset_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("areset_alu_a", bus.alu_a, 32'd0);
    check("areset_alu_op", 32'(bus.alu_op), 32'd0);
    de_clear();
    #2;
    resetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage that registers a decoded instruction and delivers the fully resolved operands A, B and the 4-bit ALU opcode to the combinational ALU in the execute stage. It resolves data hazards at capture time by forwarding from the EX, MEM and WB write ports. It stalls decode on a load-use hazard, and exchanges valid/allowin handshakes with decode upstream and memory downstream.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- REG_AW, 5, register address width

Ports (reset is asynchronous, active-low):
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- de_valid  in  1  decode holds an instruction
- de_ready  out  1  stage accepts the decode instruction this cycle
- de_rs_addr, de_rt_addr  in  REG_AW  source register numbers
- de_rs_val, de_rt_val  in  DATA_WIDTH  register-file read data
- de_use_rs, de_use_rt  in  1  instruction reads rs / rt
- de_imm  in  16  instruction immediate
- de_sa  in  5  shift amount
- de_a_sel  in  1  0: A=rs, 1: A=zero-extended sa
- de_b_sel  in  2  0: rt, 1: sign-extended imm, 2: zero-extended imm, 3: zero
- de_alu_op  in  4  ALU opcode
- de_dest  in  REG_AW  destination register
- de_wen  in  1  instruction writes back
- de_is_load  in  1  instruction is a load
- ex_alu_result  in  DATA_WIDTH  combinational ALU result of the instruction held here
- ex_allowin  in  1  memory stage accepts
- mem_wen, wb_wen  in  1  MEM / WB write-port valid and enable
- mem_dest, wb_dest  in  REG_AW  MEM / WB destination
- mem_wdata, wb_wdata  in  DATA_WIDTH  MEM / WB write data
- ex_valid  out  1  stage holds a valid instruction
- alu_a, alu_b  out  DATA_WIDTH  resolved ALU operands
- alu_op  out  4  ALU opcode
- ex_dest  out  REG_AW  destination register
- ex_wen, ex_is_load  out  1  registered control bits

## Operation
- Outgoing handshake: ex_fire = ex_valid & ex_allowin.
- Internal allowin: de_allowin = ~ex_valid | ex_allowin.
- load_hazard = ex_valid & ex_is_load & ex_wen & ex_dest≠0 & ((de_use_rs & de_rs_addr==ex_dest) | (de_use_rt & de_rt_addr==ex_dest)).
- de_ready = de_allowin & ~load_hazard.
- Capture: de_fire = de_valid & de_ready. On de_fire, all outputs load from decode and ex_valid←1.
- Empty: on ex_fire without de_fire, ex_valid←0 (a bubble under load_hazard).
- Forwarding is applied per source when its address is nonzero. Priority: EX (ex_valid & ex_wen & ~ex_is_load & ex_dest match → ex_alu_result) > MEM > WB > register-file value.
- Register 0 always resolves to 0, regardless of forwarding inputs.
- Operand A: de_a_sel=1 → {27'b0, de_sa}, else forwarded rs.
- Operand B: selected per de_b_sel; sign-extension replicates imm[15]. Encoding 3 yields 0.
- Operands are resolved only at capture. Held values are not re-forwarded while stalled downstream.
- Unknown alu_op values pass through unchanged.

## Timing
- Reset (asynchronous, active-low): ex_valid=0, alu_a=0, alu_b=0, alu_op=0, ex_dest=0, ex_wen=0, ex_is_load=0.
- Latency: one cycle from de_fire to operands on alu_a/alu_b.
- Throughput: one instruction per cycle when ex_allowin=1.
- de_ready is combinational from the current state and decode inputs. No combinational path exists from ex_alu_result to de_ready.
- Downstream stall (ex_allowin=0 with ex_valid=1): all outputs hold and de_ready=0.
- Simultaneous ex_fire and de_fire: new instruction replaces the old in the same edge, with no bubble.
- Load-use: exactly one bubble is inserted. On the following cycle the load has reached MEM and mem_wdata forwards.
- Reset asserted mid-stall: the held instruction is discarded; ex_valid=0 immediately (asynchronously).

## Structure
- Shared package (cpu_defs):
  - ALU opcode constants: AND=0, OR=1, ADD=2, LUI=3, SLTU=4, SLL=5, SUB=6, SLT=7.
  - B-select encodings.
  - DATA_WIDTH and REG_AW.
- Sub-module operand_fwd: one instance per source. Inputs are address, regfile value and the three write ports. Output is the resolved value. Purely combinational.

## Test plan
- Reset and pass-through:
  - Stimulus: reset, then de_valid with rs=$1=5, rt=$2=7, b_sel=0, op=ADD, no hazards.
  - Required: next cycle ex_valid=1, alu_a=5, alu_b=7, alu_op=2.
- EX forward:
  - Stimulus: held ADD writes $3 with ex_alu_result=0x10; next decode reads $3 as rs.
  - Required: alu_a=0x10, and the MEM value for $3 is ignored.
- Load-use:
  - Stimulus: held load writes $4; decode reads $4 as rt.
  - Required: de_ready=0 for one cycle and ex_valid=0 for one cycle. Then mem_wdata=0xABCD is captured as alu_b.
- Immediates:
  - Stimulus: imm=0x8001.
  - Required: b_sel=1 → alu_b=0xFFFF8001; b_sel=2 → 0x00008001. With a_sel=1 and sa=3: alu_a=3.
- Register zero and stall:
  - Stimulus: rs=$0 while mem_dest=0, mem_wen=1, mem_wdata=9.
  - Required: alu_a=0.
  - Stimulus: ex_allowin=0 for 3 cycles.
  - Required: outputs stable and de_ready=0.
- Asynchronous reset mid-stall:
  - Stimulus: resetn low between clock edges while ex_valid=1.
  - Required: ex_valid=0 and alu_a=0 before the next edge.
